uart_fifo_tx: RTL
=================

// Module: uart_fifo_tx
// PURPOSE
//  Parametrised UART transmit channel with an integrated synchronous FIFO. It runs
//  on a single clock and has its own baud generator. A producer writes words at any
//  rate; the block drains them automatically as serial frames with optional parity
//  and 1 or 2 stop bits. It replaces the fixed 8-bit baud/transmitter/FIFO chain.
//  Producers sit on the clk_50m domain, so no slow-clock FIFO is needed.
// PARAMETERS
//  CLK_HZ     50000000  input clock frequency, Hz
//  BAUD       115200    line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit, DIV >= 2
//  DATA_BITS  8         data bits per frame, 5..8
//  FIFO_DEPTH 16        entries, power of 2, >= 2; AW = log2(FIFO_DEPTH)
//  PARITY     0         0 = none, 1 = odd, 2 = even
//  STOP_BITS  1         1 or 2
// PORTS
//  clk_50m     in   1          system clock; all logic on rising edge
//  reset_n     in   1          asynchronous, active-low reset
//  wr_data     in   DATA_BITS  word to enqueue
//  wr_en       in   1          enqueue request; accepted when full==0
//  tx_enable   in   1          1 = permit starting new frames
//  clr_ovf     in   1          synchronous clear of overflow
//  full        out  1          FIFO holds FIFO_DEPTH words
//  empty       out  1          FIFO holds 0 words
//  used_words  out  AW+1       FIFO occupancy, 0..FIFO_DEPTH; excludes word in shifter
//  overflow    out  1          sticky: a write was rejected while full
//  tx          out  1          serial line, idle high
//  tx_busy     out  1          frame in progress
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): tx=1, tx_busy=0, overflow=0, FIFO empty (empty=1,
//    full=0, used_words=0), FSM IDLE, baud counter 0. Takes effect immediately,
//    including mid-frame. The partial frame is abandoned and never resumed.
//  - Write: if wr_en && !full, wr_data is stored at the edge and used_words +1 next cycle.
//    If wr_en && full, the data is dropped and overflow=1 next cycle.
//    Full is the registered value; a pop in the same cycle does not admit the write.
//  - overflow: stays set until clr_ovf=1. If clr_ovf and a rejected write coincide,
//    set wins.
//  - Pop: in IDLE with tx_enable && !empty, the head word loads into the shifter and
//    used_words -1. The FSM enters START and tx=0 from the next cycle.
//    Simultaneous write+pop leaves used_words unchanged.
//    A write into an empty FIFO can be popped no earlier than the following cycle.
//  - FSM: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (only if PARITY!=0)
//    -> STOP (STOP_BITS bits) -> IDLE.
//    Each bit lasts exactly DIV clocks. The baud counter restarts at 0 on entry to START.
//    Data is sent LSB first. Odd parity: XOR(data) ^ 1. Even parity: XOR(data).
//    Stop bits: tx=1.
//  - tx_busy=1 from the first START cycle to the last STOP cycle inclusive, otherwise 0.
//  - Back-to-back: after the last stop bit the FSM spends exactly 1 clock in IDLE
//    (tx=1), then starts the next frame. The inter-frame high time is therefore
//    STOP_BITS*DIV + 1 clocks.
//  - tx_enable=0 mid-frame: the current frame completes normally. No new frame starts
//    while it is 0.
//  - Pointers wrap modulo FIFO_DEPTH. full/empty are derived from used_words, never
//    from pointer equality alone.
//  - Outputs full, empty, used_words, overflow, tx and tx_busy are all registered,
//    with no combinational path from inputs.
// TESTING  (CLK_HZ=1000, BAUD=100 -> DIV=10, FIFO_DEPTH=16 unless noted)
//  1 Write 0xA5, PARITY=0, STOP_BITS=1, tx_enable=1 -> tx low 10 clk, then 1,0,1,0,0,1,0,1
//    (10 clk each), high 10 clk. tx_busy high exactly 100 clk. empty returns to 1.
//  2 PARITY=2, write 0x07 -> parity bit 1 (110 clk busy). PARITY=1, write 0x07 -> parity bit 0.
//  3 tx_enable=0, write 0x00..0x10 (17 writes) -> full=1 after the 16th, used_words=16,
//    overflow=1. Enable -> exactly 0x00..0x0F sent, 0x10 never sent.
//    clr_ovf -> overflow=0.
//  4 Burst-write 0x11,0x22,0x33 -> three frames, each start bit 11 clk after the previous
//    stop bit begins (DIV+1 high time). tx_busy low for exactly 1 clk between frames.
//  5 STOP_BITS=2, DATA_BITS=7, write 0x7F -> 10-clk start, 7 ones, 20 clk stop, busy 100 clk.
//  6 reset_n low at clk 35 of a frame -> tx=1 and tx_busy=0 without waiting for an edge,
//    used_words=0. After release, no frame until new writes.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// UART transmit channel: generic FIFO feeding a start/data/parity/stop serialiser.
// Latency: a word written into an empty FIFO drives its start bit 2 clocks later.
// Backpressure: writes are refused while full is high and set the sticky overflow flag.

// Generic synchronous FIFO with registered occupancy and full/empty flags.
// Latency: a pushed word is visible at the head (empty low) on the next clock.
// Backpressure: push is ignored while full; pop is ignored while empty.
module uart_fifo_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   used,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   used_nxt;
  logic          do_push;
  logic          do_pop;

  // Qualify requests against the registered flags only, so a same-cycle pop
  // never makes room for a write.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Occupancy for the next cycle; push and pop together cancel out.
  always_comb begin
    used_nxt = used;
    case ({do_push, do_pop})
      2'b10:   used_nxt = used + 1'b1;
      2'b01:   used_nxt = used - 1'b1;
      default: used_nxt = used;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; flags come from the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      used  <= used_nxt;
      full  <= (used_nxt == FULL_CNT);
      empty <= (used_nxt == '0);
    end
  end

endmodule

// UART transmitter with integrated FIFO, baud divider and optional parity.
// Latency: start bit begins 1 clock after the pop from IDLE; 1 idle clock between frames.
// Backpressure: wr_en is dropped while full (overflow sets); tx_enable=0 holds new frames.
module uart_fifo_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                 clk_50m,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  input  logic                 tx_enable,
  input  logic                 clr_ovf,
  output logic                 full,
  output logic                 empty,
  output logic [AW:0]          used_words,
  output logic                 overflow,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [CNT_W-1:0]     baud_cnt_nxt;
  logic [2:0]           bit_cnt;
  logic [2:0]           bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 par_bit;
  logic                 par_bit_nxt;
  logic                 tx_nxt;
  logic                 tx_busy_nxt;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head_dat;

  uart_fifo_tx_fifo #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk_50m),
    .rst_n    (reset_n),
    .push     (wr_en),
    .push_dat (wr_data),
    .pop      (pop),
    .head_dat (head_dat),
    .used     (used_words),
    .full     (full),
    .empty    (empty)
  );

  assign bit_end = (baud_cnt == DIV_LAST);

  // Sticky overflow: a rejected write wins over a simultaneous clear.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Frame sequencer: next state, next line level and datapath updates.
  // tx and tx_busy are computed one cycle ahead so the outputs are flops.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_bit_nxt  = par_bit;
    tx_nxt       = tx;
    tx_busy_nxt  = tx_busy;
    pop          = 1'b0;

    case (state)
      S_IDLE: begin
        tx_nxt       = 1'b1;
        tx_busy_nxt  = 1'b0;
        baud_cnt_nxt = '0;
        if (tx_enable && !empty) begin
          pop          = 1'b1;
          shreg_nxt    = head_dat;
          par_bit_nxt  = (^head_dat) ^ (PARITY == 1);
          state_nxt    = S_START;
          tx_nxt       = 1'b0;
          tx_busy_nxt  = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = S_DATA;
          tx_nxt       = shreg[0];
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_nxt = '0;
            if (PARITY != 0) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shreg_nxt   = shreg >> 1;
            tx_nxt      = shreg[1];
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = '0;
          state_nxt    = S_STOP;
          tx_nxt       = 1'b1;
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_cnt_nxt = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_IDLE;
            tx_nxt      = 1'b1;
            tx_busy_nxt = 1'b0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt    = S_IDLE;
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        tx_nxt       = 1'b1;
        tx_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered line outputs; reset abandons any frame.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      par_bit  <= par_bit_nxt;
      tx       <= tx_nxt;
      tx_busy  <= tx_busy_nxt;
    end
  end

endmodule
